// File: rtl/seg_seq_player.sv
// rtl/seg_seq_player.sv - programmable step list played back onto the 7-segment display controls
module seg_seq_player #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [5:0]               i_wr_data,
    input  logic                     i_clr,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_hold,
    input  logic                     i_loop,
    output logic [3:0]               o_sel,
    output logic                     o_blink,
    output logic                     o_fx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int DW = $clog2(TICK_DIV);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    localparam logic [CW-1:0] FULL       = CW'(DEPTH);
    localparam logic [DW-1:0] DWELL_LAST = DW'(TICK_DIV - 1);

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic [DW-1:0] dwell;
    logic [5:0]    mem [DEPTH];

    logic          wr_ok;
    logic          start_ok;
    logic          tick_end;
    logic          at_last;
    logic [IW-1:0] idx_nxt;

    always_comb begin
        wr_ok    = (state == ST_IDLE) && i_wr_en && !i_start && !i_clr && (count != FULL);
        start_ok = (state == ST_IDLE) && i_start && !i_stop && !i_clr && (count != '0);
        tick_end = (dwell == DWELL_LAST) && !i_hold;
        // count is frozen and non-zero while playing, so count-1 is the last valid index
        at_last  = ({1'b0, idx} == (count - CW'(1)));
        idx_nxt  = at_last ? '0 : idx + IW'(1);
    end

    // Step storage carries no reset; count alone defines which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_rst && wr_ok) begin
            mem[count[IW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            idx     <= '0;
            dwell   <= '0;
            o_sel   <= '0;
            o_blink <= 1'b0;
            o_fx    <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (i_clr) begin
                    count <= '0;
                end else if (wr_ok) begin
                    count <= count + CW'(1);
                end
                if (start_ok) begin
                    state                  <= ST_PLAY;
                    o_busy                 <= 1'b1;
                    idx                    <= '0;
                    dwell                  <= '0;
                    {o_fx, o_blink, o_sel} <= mem[0];
                end
            end else if (i_stop) begin
                state                  <= ST_IDLE;
                o_busy                 <= 1'b0;
                idx                    <= '0;
                dwell                  <= '0;
                {o_fx, o_blink, o_sel} <= '0;
            end else if (tick_end) begin
                dwell <= '0;
                if (at_last && !i_loop) begin
                    state                  <= ST_IDLE;
                    o_busy                 <= 1'b0;
                    o_done                 <= 1'b1;
                    idx                    <= '0;
                    {o_fx, o_blink, o_sel} <= '0;
                end else begin
                    idx                    <= idx_nxt;
                    {o_fx, o_blink, o_sel} <= mem[idx_nxt];
                end
            end else if (!i_hold) begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    assign o_count = count;

endmodule

// File: doc/seg_seq_player.md
Name: seg_seq_player

Overview:
- Upstream sequencer for the 7-segment display top level.
- Stores a short programmed list of display steps. Each step is {fx, blink, sel[3:0]}.
- Plays the steps back one per dwell period on o_sel/o_blink/o_fx, which drive the display's digit-select, blink and effect-mux inputs directly.
- Lets the display run an autonomous message or animation without external pin toggling.

Parameters:
- DEPTH, 8: number of step entries; power of two, 2..16.
- TICK_DIV, 1000: clock cycles each step is held; must be at least 2.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  synchronous reset, active-low; sampled on the rising edge of i_clk.
- i_wr_en  input  1  append one step to the list; accepted only in IDLE.
- i_wr_data  input  6  step to append: [5]=fx, [4]=blink, [3:0]=sel.
- i_clr  input  1  empty the list (count to 0); accepted only in IDLE.
- i_start  input  1  begin playback from entry 0.
- i_stop  input  1  abort playback and return to IDLE.
- i_hold  input  1  level; while high in PLAY, the dwell counter freezes.
- i_loop  input  1  level, sampled at end of the last entry; 1 = wrap to entry 0, 0 = finish.
- o_sel  output  4  current step digit select.
- o_blink  output  1  current step blink enable.
- o_fx  output  1  current step effect select.
- o_busy  output  1  high in PLAY.
- o_done  output  1  one-cycle pulse when non-looped playback completes.
- o_count  output  log2(DEPTH)+1  number of stored entries.

Behaviour:
- Reset (i_rst low at a clock edge):
  - state=IDLE; count, write pointer, play index and dwell counter all 0.
  - o_sel=0, o_blink=0, o_fx=0, o_busy=0, o_done=0.
  - Memory contents need not be cleared.
  - Reset mid-playback aborts on that edge with no o_done.
- Storage: DEPTH x 6-bit register array. A write goes to entry[count], then count increments.
- Writes are ignored in these cases:
  - count==DEPTH (full); no wrap, no overwrite.
  - state is PLAY.
  - i_start or i_clr is high in the same cycle.
- Clear: i_clr in IDLE sets count=0; array contents are don't-care. Clear and start in the same cycle: clear wins, start ignored.
- FSM, two states: IDLE and PLAY.
  - IDLE -> PLAY: i_start=1, i_stop=0, count>0, i_clr=0. Sets index=0 and dwell=0.
  - i_start with count==0 is ignored; state stays IDLE.
  - PLAY -> IDLE on i_stop: takes effect on that edge; outputs cleared next cycle; no o_done. i_stop outranks every other input.
  - i_start in PLAY is ignored; no restart.
- Timing in PLAY:
  - All outputs are registered.
  - The edge that enters PLAY, or advances the index, loads o_sel/o_blink/o_fx from the new entry. The values are visible in the following cycle, giving one cycle latency from i_start to entry 0 on the outputs.
  - Dwell counter runs 0..TICK_DIV-1 and increments each cycle when i_hold=0. With i_hold=1 it and the outputs hold their value.
  - When dwell==TICK_DIV-1 and i_hold=0, the dwell counter returns to 0 and:
    - if index<count-1: index increments.
    - if index==count-1 and i_loop=1: index becomes 0.
    - if index==count-1 and i_loop=0: state becomes IDLE, o_done=1 for exactly one cycle, and outputs clear to 0 in the same cycle.
  - Without hold, each entry is presented for exactly TICK_DIV cycles.
  - count==1 with i_loop=1: entry 0 is shown continuously; no output glitch at the wrap.
- In IDLE: o_sel, o_blink and o_fx are all 0.
- o_busy equals (state==PLAY) and is registered with the state.
- o_count reflects count the cycle after a write or clear.

Test Plan:
- Reset and load: drive i_rst low 2 cycles, then write 3 entries 0x01, 0x12, 0x23 -> o_count=3, outputs 0, o_busy=0.
- Non-loop playback (TICK_DIV=4, i_loop=0), i_start at cycle T:
  - o_sel=1 over T+1..T+4, blink=0, fx=0.
  - o_sel=2 with blink=1 over T+5..T+8.
  - o_sel=3 with fx=1 over T+9..T+12.
  - At T+13: o_done=1 for 1 cycle, outputs 0, o_busy=0.
- Loop and hold: i_loop=1 -> sequence 1,2,3,1,2 continues. Holding i_hold high 5 cycles during entry 2 stretches it to 9 cycles, with no other change.
- Full and locked writes:
  - Write DEPTH+2 entries -> o_count=DEPTH, and the extra writes do not alter entry 0 (check by playback).
  - A write during PLAY -> o_count unchanged.
- Priority:
  - i_start and i_stop together in IDLE -> stays IDLE.
  - i_stop mid-entry -> o_busy=0 next cycle, no o_done.
  - i_clr with i_start -> o_count=0, stays IDLE.
  - i_start with count=0 -> ignored.
- Reset mid-play: pull i_rst low during entry 2 -> next cycle all outputs 0 and o_count=0, no o_done.
